fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues single-outstanding word reads,
// buffers responses in a 2-entry queue and presents the head to the decoder.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [5:0]        opcode,
  output logic [5:0]        func,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc4,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, STALL, FLUSH} state_t;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_n, addr_n;
  logic              req_n;

  // Entry 0 is the head and drives inst/pc_out directly; entry 1 is the tail.
  logic [31:0]       w1_q, w0_n, w1_n;
  logic [ADDR_W-1:0] pc1_q, pc0_n, pc1_n;
  logic              v1_q, v0_n, v1_n;

  logic              ack_ok, pending, push, pop, space;
  logic [1:0]        occ_next;

  assign ack_ok  = imem_req & imem_ack;
  assign pending = imem_req & ~imem_ack;
  assign pop     = inst_valid & inst_ready;
  // A response arriving in FLUSH, or alongside a redirect, belongs to the old stream.
  assign push    = ack_ok & (state_q != FLUSH) & ~redirect;

  assign occ_next = redirect ? 2'd0
                             : {1'b0, inst_valid} + {1'b0, v1_q} - {1'b0, pop} + {1'b0, push};
  assign space    = (occ_next + {1'b0, pending}) < 2'd2;

  assign opcode = inst[31:26];
  assign func   = inst[5:0];
  assign pc4    = pc_out + ADDR_W'(4);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    w0_n  = inst;
    pc0_n = pc_out;
    v0_n  = inst_valid;
    w1_n  = w1_q;
    pc1_n = pc1_q;
    v1_n  = v1_q;
    if (pop) begin
      w0_n  = w1_q;
      pc0_n = pc1_q;
      v0_n  = v1_q;
      v1_n  = 1'b0;
    end
    if (push) begin
      if (!v0_n) begin
        w0_n  = imem_rdata;
        pc0_n = imem_addr;
        v0_n  = 1'b1;
      end else begin
        w1_n  = imem_rdata;
        pc1_n = imem_addr;
        v1_n  = 1'b1;
      end
    end
    if (redirect) begin
      v0_n = 1'b0;
      v1_n = 1'b0;
    end
  end

  always_comb begin
    state_n    = state_q;
    req_n      = 1'b0;
    addr_n     = imem_addr;
    fetch_pc_n = fetch_pc_q;
    if (ack_ok && state_q == FETCH) fetch_pc_n = fetch_pc_q + ADDR_W'(4);
    if (redirect) fetch_pc_n = redirect_pc & ~ADDR_W'(3);

    if (pending) begin
      // The outstanding request must complete at its original address.
      req_n   = 1'b1;
      state_n = (redirect || state_q == FLUSH) ? FLUSH : FETCH;
    end else if (fetch_en && space) begin
      req_n   = 1'b1;
      addr_n  = fetch_pc_n;
      state_n = FETCH;
    end else begin
      state_n = fetch_en ? STALL : IDLE;
    end
  end

  // NOTE: queue storage is reset too, because inst and pc_out have defined reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      pc_out     <= '0;
      v1_q       <= 1'b0;
      w1_q       <= '0;
      pc1_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_n;
      fetch_pc_q <= fetch_pc_n;
      imem_req   <= req_n;
      imem_addr  <= addr_n;
      inst_valid <= v0_n;
      inst       <= w0_n;
      pc_out     <= pc0_n;
      v1_q       <= v1_n;
      w1_q       <= w1_n;
      pc1_q      <= pc1_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared against a program-order model of the delivered instruction stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [31:0] pc_out;
  logic [31:0] pc4;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .opcode(opcode), .func(func),
    .pc_out(pc_out), .pc4(pc4), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; fetch_en = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b1; imem_ack = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_handshake: req=%0b addr=%h valid=%0b, want 0/00000000/0", imem_req, imem_addr, inst_valid);
    end
    n_checks++;
    if (inst !== 32'h0 || opcode !== 6'h0 || func !== 6'h0 || pc_out !== 32'h0 || pc4 !== 32'h4) begin
      n_errors++;
      $display("FAIL reset_head: inst=%h op=%h func=%h pc=%h pc4=%h, want 0/0/0/0/4", inst, opcode, func, pc_out, pc4);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ack_ignored: req=%0b valid=%0b, want 0/0", imem_req, inst_valid);
    end
    imem_ack = 1'b0; fetch_en = 1'b0;
  endtask

  task automatic test_basic();
    apply_reset(); fetch_en = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_errors++; $display("FAIL basic_first_req: req=%0b addr=%h, want 1/00000000", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'h8C01_0004;
    @(negedge clk);
    n_checks++;
    if (inst_valid !== 1'b1 || opcode !== 6'h23 || pc_out !== 32'h0 || pc4 !== 32'h4 || inst !== 32'h8C01_0004) begin
      n_errors++;
      $display("FAIL basic_head0: valid=%0b op=%h pc=%h pc4=%h inst=%h, want 1/23/0/4/8c010004", inst_valid, opcode, pc_out, pc4, inst);
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      n_errors++; $display("FAIL basic_second_req: req=%0b addr=%h, want 1/00000004", imem_req, imem_addr);
    end
    imem_rdata = 32'h0022_1820; fetch_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (inst_valid !== 1'b1 || opcode !== 6'h0 || func !== 6'h20 || pc_out !== 32'h4 || inst !== 32'h0022_1820) begin
      n_errors++;
      $display("FAIL basic_head1: valid=%0b op=%h func=%h pc=%h inst=%h, want 1/0/20/4/00221820", inst_valid, opcode, func, pc_out, inst);
    end
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_errors++; $display("FAIL basic_idle: req=%0b, want 0", imem_req);
    end
    imem_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_errors++; $display("FAIL basic_drain: valid=%0b, want 0", inst_valid);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_stall();
    int acks, reqs;
    logic [31:0] seen_addr;
    apply_reset(); fetch_en = 1'b1; inst_ready = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      imem_ack = imem_req; imem_rdata = mem_word(imem_addr);
      if (imem_req) acks++;
    end
    n_checks++;
    if (acks != 2 || imem_req !== 1'b0 || inst_valid !== 1'b1 || pc_out !== 32'h0) begin
      n_errors++;
      $display("FAIL stall_fill: acks=%0d req=%0b valid=%0b pc=%h, want 2/0/1/0", acks, imem_req, inst_valid, pc_out);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    reqs = 0; seen_addr = '1;
    repeat (6) begin
      if (imem_req) begin reqs++; seen_addr = imem_addr; end
      imem_ack = imem_req; imem_rdata = mem_word(imem_addr);
      @(negedge clk);
    end
    n_checks++;
    if (reqs != 1 || seen_addr !== 32'h8) begin
      n_errors++; $display("FAIL stall_one_request: reqs=%0d addr=%h, want 1/00000008", reqs, seen_addr);
    end
    n_checks++;
    if (pc_out !== 32'h4 || imem_req !== 1'b0) begin
      n_errors++; $display("FAIL stall_head_after_pop: pc=%h req=%0b, want 4/0", pc_out, imem_req);
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_latency();
    logic held;
    apply_reset(); fetch_en = 1'b1; inst_ready = 1'b1; imem_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_errors++; $display("FAIL latency_req: req=%0b addr=%h, want 1/0", imem_req, imem_addr);
    end
    held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) held = 1'b0;
      if (i == 2) begin imem_ack = 1'b1; imem_rdata = mem_word(32'h0); end
    end
    n_checks++;
    if (held !== 1'b1) begin
      n_errors++; $display("FAIL latency_hold: held=%0b, want 1", held);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    n_checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h0 || inst !== mem_word(32'h0) || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      n_errors++;
      $display("FAIL latency_deliver: valid=%0b pc=%h inst=%h req=%0b addr=%h, want 1/0/%h/1/4", inst_valid, pc_out, inst, imem_req, imem_addr, mem_word(32'h0));
    end
    fetch_en = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic test_redirect_flush();
    logic seen_10;
    apply_reset(); fetch_en = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 20 && !(imem_req && imem_addr == 32'h10); i++) begin
      imem_ack = imem_req; imem_rdata = mem_word(imem_addr);
      @(negedge clk);
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      n_errors++; $display("FAIL flush_reach_10: req=%0b addr=%h, want 1/00000010", imem_req, imem_addr);
    end
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h43;
    @(negedge clk);
    redirect = 1'b0;
    seen_10 = (inst_valid === 1'b1 && pc_out === 32'h10);
    n_checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      n_errors++; $display("FAIL flush_enter: valid=%0b req=%0b addr=%h, want 0/1/00000010", inst_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = mem_word(32'h10);
    @(negedge clk);
    imem_ack = 1'b0;
    seen_10 |= (inst_valid === 1'b1 && pc_out === 32'h10);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || inst_valid !== 1'b0) begin
      n_errors++; $display("FAIL flush_resume: req=%0b addr=%h valid=%0b, want 1/00000040/0", imem_req, imem_addr, inst_valid);
    end
    imem_ack = 1'b1; imem_rdata = mem_word(32'h40);
    @(negedge clk);
    imem_ack = 1'b0; fetch_en = 1'b0;
    seen_10 |= (inst_valid === 1'b1 && pc_out === 32'h10);
    n_checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h40 || inst !== mem_word(32'h40) || seen_10) begin
      n_errors++;
      $display("FAIL flush_new_stream: valid=%0b pc=%h inst=%h seen_10=%0b, want 1/00000040/%h/0", inst_valid, pc_out, inst, seen_10, mem_word(32'h40));
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_ack();
    int cnt8, cnt_c;
    logic [31:0] first_pc;
    apply_reset(); fetch_en = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 20 && !(inst_valid && pc_out == 32'h8); i++) begin
      imem_ack = imem_req; imem_rdata = mem_word(imem_addr);
      @(negedge clk);
    end
    n_checks++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h8 || imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      n_errors++; $display("FAIL redir_ack_setup: valid=%0b pc=%h req=%0b addr=%h, want 1/8/1/c", inst_valid, pc_out, imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = mem_word(32'hC); redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    n_checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_errors++; $display("FAIL redir_ack_next_req: valid=%0b req=%0b addr=%h, want 0/1/00000200", inst_valid, imem_req, imem_addr);
    end
    cnt8 = 0; cnt_c = 0; first_pc = '1;
    repeat (6) begin
      if (inst_valid) begin
        if (pc_out == 32'h8) cnt8++;
        if (pc_out == 32'hC) cnt_c++;
        if (first_pc === '1) first_pc = pc_out;
      end
      imem_ack = imem_req; imem_rdata = mem_word(imem_addr);
      @(negedge clk);
    end
    n_checks++;
    if (cnt8 != 0 || cnt_c != 0 || first_pc !== 32'h200) begin
      n_errors++; $display("FAIL redir_ack_stream: again8=%0d seenC=%0d first=%h, want 0/0/00000200", cnt8, cnt_c, first_pc);
    end
    imem_ack = 1'b0; fetch_en = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic test_reset_wrap();
    apply_reset(); fetch_en = 1'b1; inst_ready = 1'b1; imem_ack = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0; imem_ack = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0 || pc_out !== 32'h0 || pc4 !== 32'h4) begin
      n_errors++;
      $display("FAIL midreq_reset: req=%0b addr=%h valid=%0b pc=%h pc4=%h, want 0/0/0/0/4", imem_req, imem_addr, inst_valid, pc_out, pc4);
    end
    @(negedge clk);
    rst_n = 1'b1; imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      n_errors++; $display("FAIL wrap_first_req: req=%0b addr=%h, want 1/fffffffc", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = mem_word(32'hFFFF_FFFC);
    @(negedge clk);
    imem_ack = 1'b0; fetch_en = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b1 || pc_out !== 32'hFFFF_FFFC || pc4 !== 32'h0) begin
      n_errors++;
      $display("FAIL wrap_addr: req=%0b addr=%h valid=%0b pc=%h pc4=%h, want 1/0/1/fffffffc/0", imem_req, imem_addr, inst_valid, pc_out, pc4);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_addr, w;
    logic        prev_pending, prev_redirect, waiting;
    int          lat, deliveries;
    apply_reset();
    exp_pc = 32'h0; prev_pending = 1'b0; prev_redirect = 1'b0; waiting = 1'b0; lat = 0; deliveries = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (prev_pending) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          n_errors++; $display("FAIL rnd_req_hold cyc=%0d: req=%0b addr=%h, want 1/%h", cyc, imem_req, imem_addr, prev_addr);
        end
      end
      if (prev_redirect) begin
        n_checks++;
        if (inst_valid !== 1'b0) begin
          n_errors++; $display("FAIL rnd_flush_valid cyc=%0d: valid=%0b, want 0", cyc, inst_valid);
        end
      end
      inst_ready  = ($urandom_range(0, 9) < 7);
      fetch_en    = ($urandom_range(0, 9) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom();
      if (imem_req) begin
        if (!waiting) begin waiting = 1'b1; lat = $urandom_range(0, 3); end
        if (lat == 0) begin
          imem_ack = 1'b1; imem_rdata = mem_word(imem_addr); waiting = 1'b0;
        end else begin
          imem_ack = 1'b0; imem_rdata = $urandom(); lat--;
        end
      end else begin
        imem_ack = 1'b0; imem_rdata = $urandom();
      end
      if (inst_valid && inst_ready) begin
        w = mem_word(exp_pc);
        n_checks++;
        if (pc_out !== exp_pc || inst !== w || opcode !== w[31:26] || func !== w[5:0] || pc4 !== exp_pc + 32'd4) begin
          n_errors++;
          $display("FAIL rnd_deliver cyc=%0d: pc=%h inst=%h op=%h func=%h pc4=%h, want pc=%h inst=%h", cyc, pc_out, inst, opcode, func, pc4, exp_pc, w);
        end
        exp_pc += 32'd4;
        deliveries++;
      end
      if (redirect) exp_pc = redirect_pc & ~32'h3;
      prev_pending  = imem_req && !imem_ack;
      prev_addr     = imem_addr;
      prev_redirect = redirect;
      @(negedge clk);
    end
    redirect = 1'b0; imem_ack = 1'b0; fetch_en = 1'b0; inst_ready = 1'b0;
    n_checks++;
    if (deliveries < 100) begin
      n_errors++; $display("FAIL rnd_progress: deliveries=%0d, want >= 100", deliveries);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_latency();
    test_redirect_flush();
    test_redirect_ack();
    test_reset_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
